luces_monitor: RTL and testbench

- Receive-side checker for the 5-LED bounce ("chaser") pattern that the light-driver block produces.
- Samples the 5-bit LED bus on a strobe and recovers the generator's 3-bit phase, LED position and sweep direction.
- Verifies every step against the legal 8-phase bounce sequence and reports lock status and error counts.
- Sits on the board-test path, fed either from the driver's LED outputs or from looped-back pins.

---
 rtl/luces_monitor.sv | 124 ++++++++++++
 tb/tb_luces_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/luces_monitor.sv
// rtl/luces_monitor.sv - receive-side checker for the 5-LED bounce (chaser) pattern
module luces_monitor #(
  parameter int LOCK_COUNT = 8,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       leds_in,
  input  logic             sample_en,
  output logic [2:0]       phase,
  output logic [2:0]       position,
  output logic             dir,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {HUNT, LOCKING, LOCKED} state_t;

  localparam logic [7:0]       LOCK_CNT = LOCK_COUNT[7:0];
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [2:0]       phase_q, position_q;
  logic             dir_q, locked_q, err_q;
  logic [ERR_W-1:0] err_count_q;
  logic [7:0]       match_cnt_q;

  logic [2:0] next_phase;
  logic [4:0] expected;

  function automatic logic [4:0] pattern_of(input logic [2:0] p);
    case (p)
      3'd0:    pattern_of = 5'b10000;
      3'd1:    pattern_of = 5'b01000;
      3'd2:    pattern_of = 5'b00100;
      3'd3:    pattern_of = 5'b00010;
      3'd4:    pattern_of = 5'b00001;
      3'd5:    pattern_of = 5'b00010;
      3'd6:    pattern_of = 5'b00100;
      default: pattern_of = 5'b01000;
    endcase
  endfunction

  // Phases 5..7 retrace positions 3..1 on the return sweep.
  function automatic logic [2:0] position_of(input logic [2:0] p);
    position_of = (p <= 3'd4) ? p : 3'd0 - p;
  endfunction

  assign next_phase = phase_q + 3'd1;
  assign expected   = pattern_of(next_phase);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      phase_q     <= 3'd0;
      position_q  <= 3'd0;
      dir_q       <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      match_cnt_q <= 8'd0;
    end else begin
      err_q <= 1'b0;
      if (sample_en) begin
        case (state_q)
          HUNT: begin
            if (leds_in == 5'b10000 || leds_in == 5'b00001) begin
              phase_q     <= (leds_in == 5'b10000) ? 3'd0 : 3'd4;
              position_q  <= (leds_in == 5'b10000) ? 3'd0 : 3'd4;
              dir_q       <= 1'b0;
              match_cnt_q <= 8'd1;
              if (LOCK_CNT == 8'd1) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                state_q <= LOCKING;
              end
            end
          end
          LOCKING: begin
            // expected is one-hot, so an invalid pattern always mismatches
            if (leds_in == expected) begin
              phase_q     <= next_phase;
              position_q  <= position_of(next_phase);
              dir_q       <= (next_phase >= 3'd5);
              match_cnt_q <= match_cnt_q + 8'd1;
              if (match_cnt_q + 8'd1 == LOCK_CNT) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              state_q     <= HUNT;
              match_cnt_q <= 8'd0;
            end
          end
          default: begin
            if (leds_in == expected) begin
              phase_q    <= next_phase;
              position_q <= position_of(next_phase);
              dir_q      <= (next_phase >= 3'd5);
            end else begin
              state_q     <= HUNT;
              locked_q    <= 1'b0;
              err_q       <= 1'b1;
              match_cnt_q <= 8'd0;
              if (err_count_q != ERR_MAX)
                err_count_q <= err_count_q + ERR_ONE;
            end
          end
        endcase
      end
    end
  end

  assign phase     = phase_q;
  assign position  = position_q;
  assign dir       = dir_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_luces_monitor.sv
// tb/tb_luces_monitor.sv - directed self-checking bench for luces_monitor
module tb_luces_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] leds_in = 5'b0;
  logic       sample_en = 1'b0;
  logic [2:0] phase, position;
  logic       dir, locked, err;
  logic [7:0] err_count;

  logic [4:0] leds2 = 5'b0;
  logic       en2 = 1'b0;
  logic [2:0] phase2, position2;
  logic       dir2, locked2, err2;
  logic [1:0] err_count2;

  int tests = 0;
  int failed = 0;
  logic [4:0] pat [8];

  luces_monitor #(.LOCK_COUNT(8), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .leds_in(leds_in), .sample_en(sample_en),
    .phase(phase), .position(position), .dir(dir), .locked(locked),
    .err(err), .err_count(err_count)
  );

  luces_monitor #(.LOCK_COUNT(1), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .leds_in(leds2), .sample_en(en2),
    .phase(phase2), .position(position2), .dir(dir2), .locked(locked2),
    .err(err2), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [4:0] p);
    leds_in = p;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
  endtask

  task automatic strobe2(input logic [4:0] p);
    leds2 = p;
    en2 = 1'b1;
    @(posedge clk); #1;
    en2 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // From HUNT: full 8-step acquisition, then advance to the target phase while locked
  task automatic lock_to(input int target);
    for (int i = 0; i < 8; i++) strobe(pat[i]);
    for (int i = 0; i <= target; i++) strobe(pat[i]);
  endtask

  initial begin
    pat[0] = 5'b10000; pat[1] = 5'b01000; pat[2] = 5'b00100; pat[3] = 5'b00010;
    pat[4] = 5'b00001; pat[5] = 5'b00010; pat[6] = 5'b00100; pat[7] = 5'b01000;

    // Reset with strobes active
    @(posedge clk); #1;
    rst = 1'b1;
    leds_in = 5'b10000; leds2 = 5'b10000;
    for (int i = 0; i < 2; i++) begin
      sample_en = 1'b1; en2 = 1'b1;
      @(posedge clk); #1;
      chk("rst_phase", phase, 0);
      chk("rst_locked", locked, 0);
      chk("rst_err", err, 0);
      chk("rst_cnt", err_count, 0);
      chk("rst_locked2", locked2, 0);
    end
    rst = 1'b0; sample_en = 1'b0; en2 = 1'b0;
    idle(1);

    // Clean acquisition
    for (int i = 0; i < 8; i++) begin
      strobe(pat[i]);
      chk($sformatf("acq_phase%0d", i), phase, i);
      chk($sformatf("acq_locked%0d", i), locked, (i == 7) ? 1 : 0);
    end
    chk("acq_pos7", position, 1);
    chk("acq_dir7", dir, 1);
    strobe(5'b10000);
    chk("wrap_phase", phase, 0);
    chk("wrap_dir", dir, 0);
    chk("wrap_pos", position, 0);
    chk("wrap_locked", locked, 1);

    // Violation while locked: two-hot pattern at phase 3
    strobe(pat[1]); strobe(pat[2]); strobe(pat[3]);
    chk("pre_viol_phase", phase, 3);
    strobe(5'b00110);
    chk("viol_err", err, 1);
    chk("viol_cnt", err_count, 1);
    chk("viol_locked", locked, 0);
    chk("viol_phase", phase, 3);
    idle(1);
    chk("viol_err_pulse", err, 0);

    // Repeated pattern is a violation
    lock_to(3);
    chk("relock", locked, 1);
    strobe(5'b00010);
    chk("rep_err", err, 1);
    chk("rep_cnt", err_count, 2);
    chk("rep_phase", phase, 3);
    chk("rep_pos", position, 3);

    // Mid-sequence start: ambiguous patterns ignored in HUNT
    strobe(5'b00100);
    chk("mid_hold1", phase, 3);
    chk("mid_err1", err, 0);
    strobe(5'b00010);
    chk("mid_hold2", phase, 3);
    chk("mid_locked", locked, 0);
    strobe(5'b00001);
    chk("mid_p4", phase, 4);
    chk("mid_pos4", position, 4);
    chk("mid_dir4", dir, 0);
    strobe(5'b00010);
    chk("mid_p5", phase, 5);
    chk("mid_pos5", position, 3);
    chk("mid_dir5", dir, 1);
    chk("mid_locked5", locked, 0);

    // Violating 10000 must not re-acquire
    strobe(5'b11111);
    lock_to(3);
    strobe(5'b10000);
    chk("noreuse_err", err, 1);
    chk("noreuse_cnt", err_count, 3);
    strobe(5'b01000);
    chk("noreuse_phase", phase, 3);
    chk("noreuse_locked", locked, 0);

    // Strobe gating, then reset colliding with a legal strobe
    rst = 1'b1; idle(1); rst = 1'b0;
    strobe(pat[0]); strobe(pat[1]); strobe(pat[2]);
    chk("gate_pre", phase, 2);
    for (int i = 0; i < 20; i++) begin
      leds_in = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      chk("gate_err", err, 0);
    end
    chk("gate_phase", phase, 2);
    chk("gate_pos", position, 2);
    chk("gate_locked", locked, 0);
    rst = 1'b1;
    leds_in = 5'b00010; sample_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; sample_en = 1'b0;
    chk("rstmid_phase", phase, 0);
    chk("rstmid_pos", position, 0);
    chk("rstmid_dir", dir, 0);
    chk("rstmid_locked", locked, 0);
    chk("rstmid_cnt", err_count, 0);
    strobe(5'b00010);
    chk("rstmid_hunt", phase, 0);

    // Saturation with ERR_W=2, LOCK_COUNT=1
    for (int k = 1; k <= 5; k++) begin
      strobe2(5'b10000);
      chk("sat_lock", locked2, 1);
      strobe2(5'b00110);
      chk("sat_err", err2, 1);
      chk($sformatf("sat_cnt%0d", k), err_count2, (k > 3) ? 3 : k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
